lane_mem_port_cntl: RTL and testbench

//  Per-lane memory port controller sitting directly below dma_cont in each stOp lane.

---
 rtl/lane_mem_port_pkg.sv | 17 +
 rtl/mem_port_rd_fifo.sv | 62 ++++++
 rtl/lane_mem_port_cntl.sv | 149 ++++++++++++++
 tb/tb_lane_mem_port_cntl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lane_mem_port_pkg.sv
// Shared types and sizing helpers for the per-lane memory port controller.
package lane_mem_port_pkg;

  typedef enum logic {
    PRI_WR = 1'b0,
    PRI_RD = 1'b1
  } mport_prio_e;

  localparam int MPORT_ADDR_W = 24;
  localparam int MPORT_DATA_W = 32;

  // Width needed to hold a count from 0 up to and including depth.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/mem_port_rd_fifo.sv
// Synchronous read-return FIFO: registered head, no push-to-pop bypass.
module mem_port_rd_fifo
  import lane_mem_port_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         reset_poweron,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         empty,
  output logic         full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = cnt_w(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign pop_data = mem[rd_ptr];

  // NOTE: storage is deliberately not reset; pointers/count define validity, and
  // leaving the array out of reset keeps it a plain register file/RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // NOTE: all sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/lane_mem_port_cntl.sv
// Per-lane memory port controller: write/read arbitration onto one single-port
// SRAM bank, read-tag pipe, credit counter and an in-order pausable return queue.
module lane_mem_port_cntl
  import lane_mem_port_pkg::*;
#(
  parameter int ADDR_W      = MPORT_ADDR_W,
  parameter int DATA_W      = MPORT_DATA_W,
  parameter int SRAM_RD_LAT = 1,
  parameter int RDQ_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              reset_poweron,
  input  logic              dma__memc__write_valid,
  input  logic [ADDR_W-1:0] dma__memc__write_address,
  input  logic [DATA_W-1:0] dma__memc__write_data,
  output logic              memc__dma__write_ready,
  input  logic              dma__memc__read_valid,
  input  logic [ADDR_W-1:0] dma__memc__read_address,
  input  logic              dma__memc__read_pause,
  output logic              memc__dma__read_ready,
  output logic [DATA_W-1:0] memc__dma__read_data,
  output logic              memc__dma__read_data_valid,
  output logic              memc__sram__cs,
  output logic              memc__sram__we,
  output logic [ADDR_W-1:0] memc__sram__addr,
  output logic [DATA_W-1:0] memc__sram__wdata,
  input  logic [DATA_W-1:0] sram__memc__rdata
);

  localparam int CNT_W = cnt_w(RDQ_DEPTH);

  mport_prio_e            prio_q;
  mport_prio_e            prio_d;
  logic                   run_q;
  logic [CNT_W-1:0]       rd_cnt;
  logic                   credit_ok;
  logic                   contend;
  logic                   wr_acc;
  logic                   rd_acc;
  logic                   rd_issue;
  logic [SRAM_RD_LAT-1:0] tag_q;
  logic                   q_push;
  logic                   q_pop;
  logic                   q_empty;
  logic                   q_full;
  logic [DATA_W-1:0]      q_head;

  // run_q holds both readies low while reset is asserted and for the first
  // cycle after release, so every output is 0 during reset.
  assign credit_ok = (rd_cnt < CNT_W'(RDQ_DEPTH));

  assign memc__dma__write_ready = run_q &
      ~(dma__memc__read_valid & credit_ok & (prio_q == PRI_RD));
  assign memc__dma__read_ready  = run_q & credit_ok &
      ~(dma__memc__write_valid & (prio_q == PRI_WR));

  assign wr_acc  = dma__memc__write_valid & memc__dma__write_ready;
  assign rd_acc  = dma__memc__read_valid & memc__dma__read_ready;
  assign contend = run_q & dma__memc__write_valid & dma__memc__read_valid & credit_ok;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    prio_d = prio_q;
    if (contend) prio_d = (prio_q == PRI_WR) ? PRI_RD : PRI_WR;
  end

  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      run_q  <= 1'b0;
      prio_q <= PRI_WR;
    end else begin
      run_q  <= 1'b1;
      prio_q <= prio_d;
    end
  end

  // Command stage: the accepted request drives the SRAM for exactly one cycle.
  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      memc__sram__cs    <= 1'b0;
      memc__sram__we    <= 1'b0;
      memc__sram__addr  <= '0;
      memc__sram__wdata <= '0;
    end else begin
      memc__sram__cs <= wr_acc | rd_acc;
      memc__sram__we <= wr_acc;
      if (wr_acc) begin
        memc__sram__addr  <= dma__memc__write_address;
        memc__sram__wdata <= dma__memc__write_data;
      end else if (rd_acc) begin
        memc__sram__addr  <= dma__memc__read_address;
      end
    end
  end

  // Tag pipe: the last stage lines up with sram__memc__rdata for the issued read.
  assign rd_issue = memc__sram__cs & ~memc__sram__we;

  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      tag_q <= '0;
    end else begin
      tag_q[0] <= rd_issue;
      for (int i = 1; i < SRAM_RD_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign q_push = tag_q[SRAM_RD_LAT-1];
  assign q_pop  = memc__dma__read_data_valid;

  mem_port_rd_fifo #(
    .DEPTH (RDQ_DEPTH),
    .W     (DATA_W)
  ) u_rd_fifo (
    .clk           (clk),
    .reset_poweron (reset_poweron),
    .push          (q_push),
    .push_data     (sram__memc__rdata),
    .pop           (q_pop),
    .pop_data      (q_head),
    .empty         (q_empty),
    .full          (q_full)
  );

  assign memc__dma__read_data_valid = ~q_empty & ~dma__memc__read_pause;
  assign memc__dma__read_data       = q_empty ? '0 : q_head;

  // Credits cover reads in flight plus queued, so a landing read always has space.
  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      rd_cnt <= '0;
    end else begin
      case ({rd_acc, q_pop})
        2'b10:   rd_cnt <= rd_cnt + 1'b1;
        2'b01:   rd_cnt <= rd_cnt - 1'b1;
        default: rd_cnt <= rd_cnt;
      endcase
    end
  end

  always @(posedge clk) begin
    if (reset_poweron) begin
      a_cnt_ovf: assert (!(rd_acc && !q_pop && rd_cnt == CNT_W'(RDQ_DEPTH)));
      a_cnt_udf: assert (!(q_pop && !rd_acc && rd_cnt == '0));
      a_q_ovf:   assert (!(q_push && !q_pop && q_full));
    end
  end

endmodule

// File: tb/tb_lane_mem_port_cntl.sv
// Directed bench for lane_mem_port_cntl with a behavioural single-port SRAM (latency 1).
module tb_lane_mem_port_cntl;

  localparam int AW = 24;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset_poweron = 1'b0;
  logic          wv = 1'b0, rv = 1'b0, rp = 1'b0;
  logic [AW-1:0] wa = '0, ra = '0;
  logic [DW-1:0] wd = '0;
  logic          wr, rr, rdv, cs, we;
  logic [AW-1:0] sa;
  logic [DW-1:0] swd, rd;
  logic [DW-1:0] srd = '0;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic [DW-1:0] sram [256];
  logic [DW-1:0] beat_q[$];
  int            beat_cyc[$];

  lane_mem_port_cntl dut (
    .clk                        (clk),
    .reset_poweron              (reset_poweron),
    .dma__memc__write_valid     (wv),
    .dma__memc__write_address   (wa),
    .dma__memc__write_data      (wd),
    .memc__dma__write_ready     (wr),
    .dma__memc__read_valid      (rv),
    .dma__memc__read_address    (ra),
    .dma__memc__read_pause      (rp),
    .memc__dma__read_ready      (rr),
    .memc__dma__read_data       (rd),
    .memc__dma__read_data_valid (rdv),
    .memc__sram__cs             (cs),
    .memc__sram__we             (we),
    .memc__sram__addr           (sa),
    .memc__sram__wdata          (swd),
    .sram__memc__rdata          (srd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial for (int i = 0; i < 256; i++) sram[i] = '0;

  always @(posedge clk) begin
    if (cs) begin
      if (we) sram[sa[7:0]] <= swd;
      else    srd <= sram[sa[7:0]];
    end
  end

  always @(negedge clk) begin
    #2;
    if (rdv === 1'b1) begin
      beat_q.push_back(rd);
      beat_cyc.push_back(cyc);
    end
  end

  task automatic idle();
    wv = 1'b0; rv = 1'b0; rp = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset_poweron = 1'b0;
    repeat (2) @(negedge clk);
    reset_poweron = 1'b1;
    @(negedge clk);
  endtask

  task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    wv = 1'b1; wa = a; wd = d;
    @(negedge clk);
    wv = 1'b0;
  endtask

  task automatic test_reset();
    reset_poweron = 1'b0; wv = 1'b1; rv = 1'b1;
    @(negedge clk); #1;
    vectors++; if ({wr, rr, rdv, cs, we} !== 5'b0) begin miscompares++; $display("FAIL reset_ctrl: got %b want 00000", {wr, rr, rdv, cs, we}); end
    vectors++; if ({sa, swd, rd} !== '0) begin miscompares++; $display("FAIL reset_bus: addr %h wdata %h rdata %h want 0", sa, swd, rd); end
    @(negedge clk);
    reset_poweron = 1'b1; idle();
    @(negedge clk); #1;
    vectors++; if ({wr, rr} !== 2'b11) begin miscompares++; $display("FAIL reset_release_ready: got %b want 11", {wr, rr}); end
  endtask

  task automatic test_write_read();
    @(negedge clk);
    wv = 1'b1; wa = 24'h10; wd = 32'hDEADBEEF; #1;
    vectors++; if (wr !== 1'b1) begin miscompares++; $display("FAIL t1_write_ready: got %b want 1", wr); end
    @(negedge clk);
    wv = 1'b0; rv = 1'b1; ra = 24'h10; #1;
    vectors++; if ({cs, we, sa, swd} !== {2'b11, 24'h10, 32'hDEADBEEF}) begin miscompares++; $display("FAIL t1_write_cmd: cs %b we %b addr %h wdata %h want 1 1 000010 deadbeef", cs, we, sa, swd); end
    vectors++; if (rr !== 1'b1) begin miscompares++; $display("FAIL t1_read_ready: got %b want 1", rr); end
    @(negedge clk);
    rv = 1'b0; #1;
    vectors++; if ({cs, we, sa, rdv} !== {2'b10, 24'h10, 1'b0}) begin miscompares++; $display("FAIL t1_read_cmd: cs %b we %b addr %h valid %b want 1 0 000010 0", cs, we, sa, rdv); end
    @(negedge clk); #1;
    vectors++; if (rdv !== 1'b0) begin miscompares++; $display("FAIL t1_valid_early: got %b want 0", rdv); end
    @(negedge clk); #1;
    vectors++; if ({rdv, rd} !== {1'b1, 32'hDEADBEEF}) begin miscompares++; $display("FAIL t1_latency_data: valid %b data %h want 1 deadbeef", rdv, rd); end
    @(negedge clk); #1;
    vectors++; if ({rdv, cs} !== 2'b00) begin miscompares++; $display("FAIL t1_after_pop: valid %b cs %b want 0 0", rdv, cs); end
  endtask

  task automatic test_arbitration();
    logic exp_w;
    do_reset();
    beat_q.delete(); beat_cyc.delete();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      wv = 1'b1; rv = 1'b1;
      wa = AW'(32'h80 + k); wd = DW'(32'h5000 + k); ra = AW'(32'h80 + k - 1);
      #1;
      exp_w = (k % 2 == 0);
      vectors++; if ({wr, rr} !== {exp_w, ~exp_w}) begin miscompares++; $display("FAIL t2_grant_%0d: wr/rr %b want %b", k, {wr, rr}, {exp_w, ~exp_w}); end
      if (k > 0) begin
        vectors++; if ({cs, we} !== {1'b1, ~exp_w}) begin miscompares++; $display("FAIL t2_cmd_%0d: cs/we %b want %b", k, {cs, we}, {1'b1, ~exp_w}); end
      end
    end
    @(negedge clk);
    wv = 1'b0; rv = 1'b0; #1;
    vectors++; if ({cs, we} !== 2'b10) begin miscompares++; $display("FAIL t2_last_cmd: cs/we %b want 10", {cs, we}); end
    @(negedge clk); #1;
    vectors++; if (cs !== 1'b0) begin miscompares++; $display("FAIL t2_cs_idle: got %b want 0", cs); end
    repeat (4) @(negedge clk);
    vectors++; if (beat_q.size() !== 4) begin miscompares++; $display("FAIL t2_beat_count: got %0d want 4", beat_q.size()); end
    else for (int i = 0; i < 4; i++) begin
      vectors++; if (beat_q[i] !== DW'(32'h5000 + 2 * i)) begin miscompares++; $display("FAIL t2_beat_%0d: got %h want %h", i, beat_q[i], 32'h5000 + 2 * i); end
    end
  endtask

  task automatic test_raw();
    write_word(24'h20, 32'h5555);
    @(negedge clk);
    beat_q.delete(); beat_cyc.delete();
    @(negedge clk);
    wv = 1'b1; wa = 24'h20; wd = 32'h1;
    @(negedge clk);
    wv = 1'b0; rv = 1'b1; ra = 24'h20; #1;
    vectors++; if (rr !== 1'b1) begin miscompares++; $display("FAIL t3_read_ready: got %b want 1", rr); end
    @(negedge clk);
    rv = 1'b0;
    repeat (4) @(negedge clk);
    vectors++; if (beat_q.size() !== 1 || beat_q[0] !== 32'h1) begin miscompares++; $display("FAIL t3_raw_data: beats %0d first %h want 1 beat of 00000001", beat_q.size(), (beat_q.size() > 0) ? beat_q[0] : 32'hx); end
  endtask

  task automatic test_pause();
    logic exp_r;
    int   n;
    for (int i = 0; i < 6; i++) write_word(AW'(i), DW'(32'hA0 + i));
    @(negedge clk);
    rp = 1'b1; n = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      rv = 1'b1; ra = AW'(n); #1;
      exp_r = (k < 4);
      vectors++; if ({rr, rdv} !== {exp_r, 1'b0}) begin miscompares++; $display("FAIL t4_paused_%0d: ready/valid %b want %b", k, {rr, rdv}, {exp_r, 1'b0}); end
      if (exp_r) n++;
    end
    @(negedge clk);
    rp = 1'b0; ra = 24'h4; #1;
    vectors++; if ({rr, rdv, rd} !== {2'b01, 32'hA0}) begin miscompares++; $display("FAIL t4_release_0: ready %b valid %b data %h want 0 1 000000a0", rr, rdv, rd); end
    @(negedge clk); #1;
    vectors++; if ({rr, rdv, rd} !== {2'b11, 32'hA1}) begin miscompares++; $display("FAIL t4_release_1: ready %b valid %b data %h want 1 1 000000a1", rr, rdv, rd); end
    @(negedge clk);
    ra = 24'h5; #1;
    vectors++; if ({rr, rdv, rd} !== {2'b11, 32'hA2}) begin miscompares++; $display("FAIL t4_release_2: ready %b valid %b data %h want 1 1 000000a2", rr, rdv, rd); end
    @(negedge clk);
    rv = 1'b0; #1;
    vectors++; if ({rdv, rd} !== {1'b1, 32'hA3}) begin miscompares++; $display("FAIL t4_release_3: valid %b data %h want 1 000000a3", rdv, rd); end
    @(negedge clk); #1;
    vectors++; if ({rdv, rd} !== {1'b1, 32'hA4}) begin miscompares++; $display("FAIL t4_late_4: valid %b data %h want 1 000000a4", rdv, rd); end
    @(negedge clk); #1;
    vectors++; if ({rdv, rd} !== {1'b1, 32'hA5}) begin miscompares++; $display("FAIL t4_late_5: valid %b data %h want 1 000000a5", rdv, rd); end
    @(negedge clk); #1;
    vectors++; if (rdv !== 1'b0) begin miscompares++; $display("FAIL t4_drained: valid %b want 0", rdv); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) write_word(AW'(32'h40 + i), DW'(32'hC000 + 3 * i));
    @(negedge clk);
    beat_q.delete(); beat_cyc.delete();
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      rv = 1'b1; ra = AW'(32'h40 + k); #1;
      vectors++; if (rr !== 1'b1) begin miscompares++; $display("FAIL t5_ready_%0d: got %b want 1", k, rr); end
    end
    @(negedge clk);
    rv = 1'b0;
    repeat (5) @(negedge clk);
    vectors++; if (beat_q.size() !== 16) begin miscompares++; $display("FAIL t5_beat_count: got %0d want 16", beat_q.size()); end
    else for (int i = 0; i < 16; i++) begin
      vectors++; if (beat_q[i] !== DW'(32'hC000 + 3 * i)) begin miscompares++; $display("FAIL t5_beat_%0d: got %h want %h", i, beat_q[i], 32'hC000 + 3 * i); end
      if (i > 0) begin
        vectors++; if (beat_cyc[i] - beat_cyc[i-1] !== 1) begin miscompares++; $display("FAIL t5_gap_%0d: got %0d cycles want 1", i, beat_cyc[i] - beat_cyc[i-1]); end
      end
    end
  endtask

  task automatic test_reset_inflight();
    logic exp_r;
    rp = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      rv = 1'b1; ra = AW'(k); #1;
      vectors++; if (rr !== 1'b1) begin miscompares++; $display("FAIL t6_issue_%0d: got %b want 1", k, rr); end
    end
    @(negedge clk);
    rv = 1'b0; rp = 1'b0; #1;
    vectors++; if ({rdv, rd} !== {1'b1, 32'hA0}) begin miscompares++; $display("FAIL t6_pre_reset: valid %b data %h want 1 000000a0", rdv, rd); end
    wv = 1'b1; rv = 1'b1; reset_poweron = 1'b0; #1;
    vectors++; if ({wr, rr, rdv, cs, we} !== 5'b0) begin miscompares++; $display("FAIL t6_async_ctrl: got %b want 00000", {wr, rr, rdv, cs, we}); end
    vectors++; if ({sa, swd, rd} !== '0) begin miscompares++; $display("FAIL t6_async_bus: addr %h wdata %h rdata %h want 0", sa, swd, rd); end
    repeat (2) @(negedge clk);
    reset_poweron = 1'b1; idle();
    beat_q.delete(); beat_cyc.delete();
    repeat (8) @(negedge clk);
    vectors++; if (beat_q.size() !== 0) begin miscompares++; $display("FAIL t6_stray_valid: got %0d beats want 0", beat_q.size()); end
    rp = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      rv = 1'b1; ra = AW'(k); #1;
      exp_r = (k < 4);
      vectors++; if (rr !== exp_r) begin miscompares++; $display("FAIL t6_credit_%0d: got %b want %b", k, rr, exp_r); end
    end
    @(negedge clk);
    rv = 1'b0;
    repeat (3) @(negedge clk);
    rp = 1'b0;
    repeat (6) @(negedge clk);
    vectors++; if (beat_q.size() !== 4) begin miscompares++; $display("FAIL t6_drain_count: got %0d want 4", beat_q.size()); end
    else for (int i = 0; i < 4; i++) begin
      vectors++; if (beat_q[i] !== DW'(32'hA0 + i)) begin miscompares++; $display("FAIL t6_drain_%0d: got %h want %h", i, beat_q[i], 32'hA0 + i); end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_arbitration();
    test_raw();
    test_pause();
    test_back_to_back();
    test_reset_inflight();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within 200000 time units");
    $fatal(1);
  end

endmodule
